// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the MEM-stage SRAM sequencer: widths, state encoding,
// parameter defaults and the byte-address to half-word-pair mapping.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W     = 18;
  localparam int unsigned SRAM_DATA_W     = 16;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned WORD_IDX_W      = SRAM_ADDR_W - 1;

  localparam int unsigned DEF_WAIT_CYCLES = 1;
  localparam int unsigned DEF_ADDR_BASE   = 1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // 32-bit word index inside the SRAM; out-of-window addresses simply wrap.
  function automatic logic [WORD_IDX_W-1:0] sram_word(input logic [WORD_W-1:0] address,
                                                      input logic [WORD_W-1:0] base);
    return WORD_IDX_W'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits one 32-bit pipeline load/store into low then high 16-bit SRAM phases,
// each held WAIT_CYCLES+1 cycles; ready stalls the pipeline while busy.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WORD_W-1:0]      address,
  input  logic [WORD_W-1:0]      wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [1:0]             state,    state_nxt;
  logic [CNT_W-1:0]       cnt,      cnt_nxt;
  logic                   op_wr,    op_wr_nxt;
  logic [WORD_IDX_W-1:0]  word_q,   word_nxt;
  logic [WORD_W-1:0]      wdata_q,  wdata_nxt;
  logic [WORD_W-1:0]      rdata_nxt;
  logic [SRAM_ADDR_W-1:0] addr_nxt;
  logic                   ce_nxt, oe_nxt, we_nxt;
  logic                   dq_oe,    dq_oe_nxt;
  logic [SRAM_DATA_W-1:0] dq_out,   dq_out_nxt;
  logic                   phase_end;
  logic [WORD_IDX_W-1:0]  req_word;

  // Both byte lanes are always enabled: every access moves a full half-word.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

  assign ready = ((state == ST_IDLE) && !rd_en && !wr_en) || (state == ST_DONE);

  assign req_word = sram_word(address, WORD_W'(ADDR_BASE));

  // Next-state and next-output decode; bus strobes are registered so they
  // change only on clock edges and stay glitch-free for the SRAM.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_wr_nxt  = op_wr;
    word_nxt   = word_q;
    wdata_nxt  = wdata_q;
    rdata_nxt  = rdata;
    addr_nxt   = SRAM_ADDR;
    ce_nxt     = SRAM_CE_N;
    oe_nxt     = SRAM_OE_N;
    we_nxt     = SRAM_WE_N;
    dq_oe_nxt  = dq_oe;
    dq_out_nxt = dq_out;
    phase_end  = (cnt == CNT_W'(WAIT_CYCLES));

    case (state)
      ST_IDLE: begin
        if (wr_en || rd_en) begin
          state_nxt  = ST_LO;
          cnt_nxt    = '0;
          op_wr_nxt  = wr_en;
          word_nxt   = req_word;
          wdata_nxt  = wdata;
          addr_nxt   = {req_word, 1'b0};
          ce_nxt     = 1'b0;
          oe_nxt     = wr_en;
          we_nxt     = !wr_en;
          dq_oe_nxt  = wr_en;
          dq_out_nxt = wdata[SRAM_DATA_W-1:0];
        end
      end
      ST_LO: begin
        if (phase_end) begin
          state_nxt  = ST_HI;
          cnt_nxt    = '0;
          addr_nxt   = {word_q, 1'b1};
          dq_out_nxt = wdata_q[WORD_W-1:SRAM_DATA_W];
          if (!op_wr) rdata_nxt[SRAM_DATA_W-1:0] = SRAM_DQ;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (phase_end) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
          ce_nxt    = 1'b1;
          oe_nxt    = 1'b1;
          we_nxt    = 1'b1;
          dq_oe_nxt = 1'b0;
          if (!op_wr) rdata_nxt[WORD_W-1:SRAM_DATA_W] = SRAM_DQ;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reset aborts any access in flight; the SRAM keeps whatever was written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_wr     <= op_wr_nxt;
      word_q    <= word_nxt;
      wdata_q   <= wdata_nxt;
      rdata     <= rdata_nxt;
      SRAM_ADDR <= addr_nxt;
      SRAM_CE_N <= ce_nxt;
      SRAM_OE_N <= oe_nxt;
      SRAM_WE_N <= we_nxt;
      dq_oe     <= dq_oe_nxt;
      dq_out    <= dq_out_nxt;
    end
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Sequencing controller for the external 16-bit SRAM behind the MEM stage.
- Converts one 32-bit read or write from the pipeline into two 16-bit SRAM phases (low half-word, then high half-word), each held for a programmable number of wait states.
- Deasserts `ready` while busy; the pipeline uses `~ready` to freeze IF, ID, EXE and MEM pipeline registers.

Parameters:
- `WAIT_CYCLES`, 1: extra cycles each half-word phase is held beyond the first (phase length = `WAIT_CYCLES`+1).
- `ADDR_BASE`, 1024: byte address subtracted from `address` before mapping to the SRAM.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write request (MEM_W_EN from the EXE/MEM register)
- `rd_en`  in  1  read request (MEM_R_EN from the EXE/MEM register)
- `address`  in  32  byte address (ALU result)
- `wdata`  in  32  store data (Rm value)
- `rdata`  out  32  load data
- `ready`  out  1  high = no access in progress or access completing this cycle
- `SRAM_DQ`  inout  16  SRAM data bus
- `SRAM_ADDR`  out  18  SRAM half-word address
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`  out  1 each  SRAM strobes, active low

Behaviour:
- Reset is synchronous and active-high; one clock, `clk`; `rst` sampled only on the rising edge of `clk`.
- Reset values:
  - state = IDLE, wait counter = 0
  - `rdata` = 0
  - `SRAM_ADDR` = 0, `SRAM_CE_N` = 1, `SRAM_OE_N` = 1, `SRAM_WE_N` = 1
  - `SRAM_UB_N` = 0, `SRAM_LB_N` = 0
  - `SRAM_DQ` high-Z
- Address mapping:
  - word = (`address` − `ADDR_BASE`)[18:2], computed modulo 2^32.
  - Low-phase `SRAM_ADDR` = {word[16:0], 0}; high-phase `SRAM_ADDR` = {word[16:0], 1}.
  - No range check; out-of-range addresses wrap.
- States: IDLE → LO → HI → DONE → IDLE.
  - IDLE:
    - `rd_en` or `wr_en` high → latch op, word and `wdata`; go to LO; counter = 0.
    - Both high → write wins.
    - Neither high → stay in IDLE.
  - LO / HI:
    - Hold `SRAM_ADDR`, `SRAM_CE_N` = 0 and the strobes stable for `WAIT_CYCLES`+1 cycles.
    - Counter increments each cycle; on counter = `WAIT_CYCLES`, clear the counter and advance (LO→HI, HI→DONE).
  - DONE: single cycle, then IDLE unconditionally.
- `ready` is combinational:
  - 1 when (state = IDLE and !`rd_en` and !`wr_en`) or state = DONE.
  - 0 otherwise, including the IDLE cycle in which a request arrives.
- Latency: request seen in cycle 0 → `ready` = 1 in cycle 2(`WAIT_CYCLES`+1)+1 (cycle 5 for the default).
- Writes:
  - `SRAM_WE_N` = 0 and `SRAM_OE_N` = 1 throughout LO and HI.
  - `SRAM_DQ` driven with `wdata`[15:0] in LO and `wdata`[31:16] in HI.
- Reads:
  - `SRAM_OE_N` = 0 and `SRAM_WE_N` = 1 in LO and HI; `SRAM_DQ` high-Z.
  - Low half captured into `rdata`[15:0] on the last LO cycle; high half into `rdata`[31:16] on the last HI cycle.
  - `rdata` is valid from DONE and held until the next read overwrites it; writes never modify `rdata`.
- DONE and IDLE: `SRAM_CE_N` = 1, `SRAM_OE_N` = 1, `SRAM_WE_N` = 1; `SRAM_DQ` high-Z.
- Inputs changing during LO, HI or DONE are ignored; only latched values are used.
- A request still asserted in DONE is not re-accepted. The pipeline advances on that edge, so the next IDLE cycle sees the next instruction's request.
- Reset mid-access: abort immediately to the reset values; the partially written SRAM word is left as is.
- `WAIT_CYCLES` = 0: each phase lasts 1 cycle, so `ready` returns in cycle 3.

Decomposition:
- Shared package holds:
  - state encoding (IDLE = 0, LO = 1, HI = 2, DONE = 3)
  - default `ADDR_BASE` and `WAIT_CYCLES`
  - SRAM widths (addr 18, data 16)
- Single module; the wait counter is inline.
- No sub-module is natural. The top-level pipeline replaces the memory block's internal sequencing with this block plus a tri-state `SRAM_DQ` connection.

Test Plan:
- Reset: assert `rst` 2 cycles, then check `ready` = 1, `SRAM_CE_N` = `SRAM_WE_N` = `SRAM_OE_N` = 1, `SRAM_DQ` = Z, `rdata` = 0.
- Write, `WAIT_CYCLES` = 1: `wr_en` = 1, `address` = 1028, `wdata` = 0xDEADBEEF at cycle 0 → expect:
  - cycles 1–2: `SRAM_ADDR` = 2, `SRAM_DQ` = 0xBEEF, `SRAM_WE_N` = 0
  - cycles 3–4: `SRAM_ADDR` = 3, `SRAM_DQ` = 0xDEAD
  - cycle 5: `ready` = 1
  - `ready` = 0 in cycles 0–4
- Read-back: SRAM model returns 0xBEEF at address 2 and 0xDEAD at address 3; `rd_en` = 1, `address` = 1028 → `SRAM_OE_N` = 0 in cycles 1–4, `rdata` = 0xDEADBEEF in cycle 5, held through a following write to 1032.
- Simultaneous `rd_en` = `wr_en` = 1 → write sequence on the bus, `SRAM_OE_N` stays 1, `rdata` unchanged.
- Reset mid-access: `rst` = 1 during HI of a write → next cycle IDLE, `SRAM_WE_N` = 1, `SRAM_DQ` = Z, `ready` = 1 with no request.
- `WAIT_CYCLES` = 0 back-to-back: read held high across DONE → `ready` = 1 at cycles 3 and 7, two full sequences, no extra access started in a DONE cycle.
